// File: rtl/sensor_chain_scanner.sv
// Scanner for daisy-chained PISO shift registers (74HC165-style): generates load/shift
// strobes, shifts NUM_CHAINS chains in parallel, debounces snapshots and publishes them.
module sensor_chain_scanner #(
    parameter int CHAIN_BITS = 32,
    parameter int NUM_CHAINS = 2,
    parameter int CLK_DIV    = 100,
    parameter int SCAN_GAP   = 256,
    parameter int DEBOUNCE   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             continuous,
    input  logic [NUM_CHAINS-1:0]            sr_data,
    output logic                             sr_clk,
    output logic                             sr_load_n,
    output logic [NUM_CHAINS*CHAIN_BITS-1:0] sensor_data,
    output logic                             data_valid,
    output logic                             changed,
    output logic                             busy,
    output logic [15:0]                      scan_count
);

    localparam int W     = NUM_CHAINS * CHAIN_BITS;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(CHAIN_BITS + 1);
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [W-1:0] INV_MASK = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t state, state_nx;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             pending;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic             sr_clk_nx, load_n_nx;
    logic             sample_en, enter_load;

    logic [CHAIN_BITS-1:0] shadow [NUM_CHAINS];
    logic [W-1:0]          shadow_flat;
    logic [W-1:0]          candidate;
    logic [W-1:0]          prev_cand;
    logic [CNT_W-1:0]      stable_cnt, cnt_upd;
    logic                  accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(DEBOUNCE)) ? v : v + CNT_W'(1);
    endfunction

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            gap_cnt   <= '0;
            sr_clk    <= 1'b0;
            sr_load_n <= 1'b1;
        end else begin
            state     <= state_nx;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            idx       <= idx_nx;
            gap_cnt   <= gap_nx;
            sr_clk    <= sr_clk_nx;
            sr_load_n <= load_n_nx;
            // A start coinciding with LOAD entry is absorbed by the scan being launched
            if (enter_load)
                pending <= 1'b0;
            else if (start)
                pending <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        sr_clk_nx  = sr_clk;
        load_n_nx  = sr_load_n;
        idx_nx     = idx;
        gap_nx     = gap_cnt;
        sample_en  = 1'b0;
        enter_load = 1'b0;
        case (state)
            IDLE: begin
                sr_clk_nx = 1'b0;
                load_n_nx = 1'b1;
                if (tick && (pending || continuous)) begin
                    state_nx   = LOAD;
                    load_n_nx  = 1'b0;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (tick) begin
                    load_n_nx = 1'b1;
                    idx_nx    = '0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    // Sample on the tick that raises sr_clk, before the chain shifts
                    if (!sr_clk) begin
                        sr_clk_nx = 1'b1;
                        sample_en = 1'b1;
                        idx_nx    = idx + 1'b1;
                    end else begin
                        sr_clk_nx = 1'b0;
                        if (idx == IDX_W'(CHAIN_BITS))
                            state_nx = DONE;
                    end
                end
            end
            DONE: begin
                gap_nx   = '0;
                state_nx = continuous ? GAP : IDLE;
            end
            GAP: begin
                sr_clk_nx = 1'b0;
                load_n_nx = 1'b1;
                if (tick) begin
                    if (!continuous) begin
                        state_nx = IDLE;
                    end else if (gap_cnt == GAP_W'(SCAN_GAP - 1)) begin
                        state_nx   = LOAD;
                        load_n_nx  = 1'b0;
                        enter_load = 1'b1;
                    end else begin
                        gap_nx = gap_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shadow capture: first sampled bit ends up at index 0 of each chain
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (reset)
                shadow[c] <= '0;
            else if (sample_en)
                shadow[c] <= {sr_data[c], shadow[c][CHAIN_BITS-1:1]};
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int c = 0; c < NUM_CHAINS; c++)
            shadow_flat[c*CHAIN_BITS +: CHAIN_BITS] = shadow[c];
    end

    assign candidate = shadow_flat ^ INV_MASK;
    assign cnt_upd   = (candidate == prev_cand) ? sat_inc(stable_cnt) : CNT_W'(1);
    assign accept    = (cnt_upd >= CNT_W'(DEBOUNCE));

    // Debounce and publish stage
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cand   <= '0;
            stable_cnt  <= '0;
            sensor_data <= '0;
            data_valid  <= 1'b0;
            changed     <= 1'b0;
            scan_count  <= '0;
        end else begin
            data_valid <= 1'b0;
            changed    <= 1'b0;
            if (state == DONE) begin
                scan_count <= scan_count + 16'd1;
                prev_cand  <= candidate;
                stable_cnt <= cnt_upd;
                if (accept) begin
                    sensor_data <= candidate;
                    data_valid  <= 1'b1;
                    changed     <= (candidate != sensor_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_chain_scanner.sv
// Bench for sensor_chain_scanner: two 8-bit chain models, table-driven scans with
// a scoreboard queue of expected publish results, plus reset/start/continuous corner cases.
module tb_sensor_chain_scanner;

    typedef struct {
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        vld;
        logic        chg;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  sr_data;
    logic        sr_clk, sr_load_n;
    logic [15:0] sensor_data;
    logic        data_valid, changed, busy;
    logic [15:0] scan_count;

    int compared = 0;
    int mismatched = 0;

    vec_t exp_q[$];
    vec_t ck_e;
    vec_t single_tab[7];
    vec_t cont_tab[9];

    sensor_chain_scanner #(
        .CHAIN_BITS(8), .NUM_CHAINS(2), .CLK_DIV(4),
        .SCAN_GAP(2), .DEBOUNCE(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .sr_data(sr_data), .sr_clk(sr_clk), .sr_load_n(sr_load_n),
        .sensor_data(sensor_data), .data_valid(data_valid), .changed(changed),
        .busy(busy), .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    // Chain models: parallel load while load_n low, shift right on sr_clk rise, LSB out first
    logic [7:0] raw [2];
    logic [7:0] chain [2];
    logic       sr_clk_q = 1'b0;
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!sr_load_n)
                chain[c] <= raw[c];
            else if (sr_clk && !sr_clk_q)
                chain[c] <= chain[c] >> 1;
        end
        sr_clk_q <= sr_clk;
    end
    assign sr_data = {chain[1][0], chain[0][0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Waveform monitor: sr_clk rises, load-low cycles, rise spacing
    int cyc = 0;
    int rises = 0;
    int loads = 0;
    int bad_period = 0;
    int last_rise = -1;
    logic sclk_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!sr_load_n) begin
            loads++;
            last_rise = -1;
        end
        if (sr_clk && !sclk_prev) begin
            if (last_rise >= 0 && (cyc - last_rise) != 8)
                bad_period++;
            last_rise = cyc;
            rises++;
        end
        sclk_prev = sr_clk;
    end

    // Scoreboard: each completed scan pops one expected publish result
    logic [15:0] last_count = 16'd0;
    int spurious = 0;
    always @(negedge clk) begin
        if (scan_count != last_count) begin
            if (scan_count == last_count + 16'd1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_scan", 32'd1, 32'd0);
                end else begin
                    ck_e = exp_q.pop_front();
                    chk("data_valid", data_valid, ck_e.vld);
                    chk("changed", changed, ck_e.chg);
                    chk("sensor_data", sensor_data, ck_e.data);
                end
            end
            last_count = scan_count;
        end else if (data_valid || changed) begin
            spurious++;
        end
    end

    task automatic wait_scan();
        logic [15:0] base;
        int n;
        base = scan_count;
        n = 0;
        while (scan_count == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scan_timeout", 32'(scan_count == base), 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_sr_clk", sr_clk, 1'b0);
        chk("rst_sr_load_n", sr_load_n, 1'b1);
        chk("rst_sensor_data", sensor_data, 16'h0000);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_changed", changed, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_scan_count", scan_count, 16'd0);
    endtask

    task automatic run_single(input vec_t v, input logic [15:0] exp_count);
        int r0, l0, b0;
        raw[0] = v.r0;
        raw[1] = v.r1;
        exp_q.push_back(v);
        r0 = rises;
        l0 = loads;
        b0 = bad_period;
        pulse_start();
        wait_scan();
        chk("sr_clk_rises", rises - r0, 8);
        chk("load_low_cycles", loads - l0, 4);
        chk("sr_clk_period", bad_period - b0, 0);
        chk("scan_count", scan_count, exp_count);
        chk("busy_after_single", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, r0, l0;
        logic [15:0] sc;

        single_tab[0] = '{8'h5A, 8'hC3, 1'b0, 1'b0, 16'h0000};
        single_tab[1] = '{8'h5A, 8'hC3, 1'b1, 1'b1, 16'h3CA5};
        single_tab[2] = '{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5};
        single_tab[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'h3CA5};
        single_tab[4] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0000};
        single_tab[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 16'h0000};
        single_tab[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 16'hFFFF};

        cont_tab[0] = '{8'h5A, 8'hC3, 1'b0, 1'b0, 16'hFFFF};
        cont_tab[1] = '{8'h5A, 8'hC3, 1'b1, 1'b1, 16'h3CA5};
        cont_tab[2] = '{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5};
        cont_tab[3] = '{8'h52, 8'hC3, 1'b0, 1'b0, 16'h3CA5};
        cont_tab[4] = '{8'h5A, 8'hC3, 1'b0, 1'b0, 16'h3CA5};
        cont_tab[5] = '{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5};
        cont_tab[6] = '{8'h52, 8'hC3, 1'b0, 1'b0, 16'h3CA5};
        cont_tab[7] = '{8'h52, 8'hC3, 1'b1, 1'b1, 16'h3CAD};
        cont_tab[8] = '{8'h52, 8'hC3, 1'b1, 1'b0, 16'h3CAD};

        raw[0] = 8'h5A;
        raw[1] = 8'hC3;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Single-shot scans
        for (int i = 0; i < 7; i++)
            run_single(single_tab[i], 16'(i + 1));

        // Free-running scans, raw data changed between scans
        raw[0] = cont_tab[0].r0;
        raw[1] = cont_tab[0].r1;
        exp_q.push_back(cont_tab[0]);
        continuous = 1'b1;
        wait_scan();
        for (int i = 1; i < 9; i++) begin
            raw[0] = cont_tab[i].r0;
            raw[1] = cont_tab[i].r1;
            exp_q.push_back(cont_tab[i]);
            wait_scan();
        end
        continuous = 1'b0;
        wait_idle();
        chk("scan_count_cont", scan_count, 16'd16);

        // Reset after three sr_clk rises aborts the scan without publishing
        raw[0] = 8'h5A;
        raw[1] = 8'hC3;
        r0 = rises;
        pulse_start();
        n = 0;
        while ((rises - r0) < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_scan_rises", rises - r0, 3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        chk("no_pending_result", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        run_single('{8'h5A, 8'hC3, 1'b0, 1'b0, 16'h0000}, 16'd1);
        run_single('{8'h5A, 8'hC3, 1'b1, 1'b1, 16'h3CA5}, 16'd2);

        // Two start pulses while busy yield exactly one extra scan
        exp_q.push_back('{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5});
        exp_q.push_back('{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5});
        pulse_start();
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_after_start", busy, 1'b1);
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_scan();
        wait_scan();
        wait_idle();
        sc = scan_count;
        l0 = loads;
        repeat (150) @(negedge clk);
        chk("no_extra_load", loads - l0, 0);
        chk("no_extra_scan", scan_count, sc);
        chk("scan_count_pending", sc, 16'd4);

        // continuous dropped mid-SHIFT: scan still publishes, then stays idle
        exp_q.push_back('{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h3CA5});
        r0 = rises;
        continuous = 1'b1;
        n = 0;
        while ((rises - r0) < 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        continuous = 1'b0;
        wait_scan();
        chk("busy_after_cont_stop", busy, 1'b0);
        sc = scan_count;
        l0 = loads;
        repeat (150) @(negedge clk);
        chk("no_load_after_cont_stop", loads - l0, 0);
        chk("no_scan_after_cont_stop", scan_count, sc);
        chk("idle_after_cont_stop", busy, 1'b0);

        chk("spurious_pulses", spurious, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sensor_chain_scanner.md
Name: sensor_chain_scanner

Overview:
Parametrised scanner for daisy-chained parallel-in/serial-out shift registers (74HC165-style) carrying the board's piece sensors. Generates the shift clock and active-low parallel-load strobe, and shifts NUM_CHAINS chains in parallel. Debounces each snapshot over consecutive scans and publishes a stable sensor word with valid/changed pulses. Supports single-shot and free-running scan modes, and sits between the sensor PCB pins and the CPU's memory-mapped sensor register.

Parameters:
CHAIN_BITS, 32, bits shifted per chain per scan (>=2)
NUM_CHAINS, 2, independent serial data inputs, shifted simultaneously
CLK_DIV, 100, clk cycles per tick; one tick = half an sr_clk period (>=2)
SCAN_GAP, 256, idle ticks between scans in continuous mode (>=1)
DEBOUNCE, 3, consecutive identical scans required before publishing (>=1)
ACTIVE_LOW, 1, 1 = invert raw serial data before debounce and publish

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-scan request; sticky-latched until serviced
continuous  in  1  1 = free-running scans separated by SCAN_GAP ticks
sr_data  in  NUM_CHAINS  serial output of each chain; bit c = chain c
sr_clk  out  1  shift clock to all chains
sr_load_n  out  1  parallel-load strobe, active low
sensor_data  out  NUM_CHAINS*CHAIN_BITS  debounced data; chain c bit i at index c*CHAIN_BITS+i
data_valid  out  1  one-cycle pulse when a scan is accepted (stable count >= DEBOUNCE)
changed  out  1  one-cycle pulse, coincident with data_valid, when sensor_data changes value
busy  out  1  high whenever the FSM is not IDLE
scan_count  out  16  completed scans since reset, wraps 0xFFFF->0

Behaviour:
- Reset (any state, mid-scan included): sr_clk=0, sr_load_n=1, sensor_data=0, data_valid=0, changed=0, busy=0, scan_count=0. Tick counter, shadow, previous-candidate and stable count clear; pending start clears; FSM enters IDLE. No partial result is published.
- Tick: divider counts 0..CLK_DIV-1. Tick = single clk cycle where count==CLK_DIV-1. All sr_clk/sr_load_n changes and FSM moves except DONE occur on ticks.
- start is sampled every clk cycle into a pending flag, including while busy. It clears when LOAD is entered.
- IDLE: sr_clk=0, sr_load_n=1. On a tick with pending or continuous -> LOAD.
- LOAD: sr_load_n=0 for exactly one tick period (CLK_DIV cycles), sr_clk=0. On the next tick: sr_load_n=1, bit index=0 -> SHIFT.
- SHIFT: sr_clk alternates every tick, starting low.
  - On a tick driving sr_clk high, sample sr_data[c] into shadow bit [c][index], then increment index.
  - After CHAIN_BITS samples, the next tick drives sr_clk low -> DONE.
  - Scan length is (1 + 2*CHAIN_BITS) ticks.
- DONE (one clk cycle): candidate = shadow XOR {ACTIVE_LOW replicated}.
  - If candidate==previous: stable count increments, saturating at DEBOUNCE. Otherwise previous=candidate and count=1.
  - If count (post-update) >= DEBOUNCE: sensor_data=candidate and data_valid=1 for one cycle; changed=1 when candidate != old sensor_data.
  - scan_count increments on every DONE.
  - Outputs are visible in the cycle after DONE.
  - Next state: continuous -> GAP; otherwise IDLE, which services any pending start on its next tick.
- GAP: sr_clk=0, sr_load_n=1, counting SCAN_GAP ticks, then LOAD. If continuous deasserts in GAP -> IDLE at the next tick.
- continuous deasserting mid-scan: the scan completes and publishes normally.
- DEBOUNCE=1: every scan is accepted. First accepted scan after reset asserts changed iff the data is nonzero.

Test Plan:
Parameters for all scenarios: CHAIN_BITS=8, NUM_CHAINS=2, CLK_DIV=4, SCAN_GAP=2, DEBOUNCE=2, ACTIVE_LOW=1, with chain models attached.
1. Assert and hold reset 3 cycles -> sr_clk=0, sr_load_n=1, sensor_data=0x0000, data_valid=changed=busy=0, scan_count=0.
2. Chains loaded raw 0x5A (chain0) and 0xC3 (chain1); pulse start once -> sr_load_n low exactly 4 cycles, then exactly 8 sr_clk rising edges at 8-cycle period; no data_valid; scan_count=1; busy drops.
3. Repeat start with the same data -> data_valid and changed pulse together for one cycle; sensor_data=0x3CA5; scan_count=2.
4. continuous=1, data stable at 0x3CA5 -> data_valid on every scan, changed never. Flip chain0 raw bit3 for one scan only -> sensor_data unchanged, no changed. Flip it for two scans -> sensor_data=0x3CAD, changed exactly once.
5. Assert reset after 3 rising sr_clk edges of a scan -> reset values next cycle. Following start plus repeat -> full 8-bit scans, correct data.
6. Pulse start twice during a busy single scan -> exactly one additional scan. Deassert continuous mid-SHIFT -> that scan publishes, then IDLE with busy=0 and no further sr_load_n pulses.
